// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - carry-chained sliced add/sub pipeline with valid/ready handshake
// Optional signed saturation is built when ADDSUB_SAT_EN is defined.
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int SW = WIDTH / STAGES;

   logic [STAGES-1:0] v_q, v_d, v_in;
   logic [STAGES:0]   ld;

   // A stage loads when empty or when its downstream stage loads; ld[STAGES] is the output pop.
   always_comb begin
      ld         = '0;
      ld[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         ld[k] = !v_q[k] || ld[k+1];
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = v_q[STAGES-1];
   assign v_d       = (v_q & ~ld[STAGES-1:0]) | (v_in & ld[STAGES-1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
      end else begin
         v_q <= v_d;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Only operand-b slices not yet consumed travel on, so the pending width shrinks per stage.
      localparam int PW = WIDTH - k * SW;

      logic [WIDTH-1:0] sx, x_d;
      logic [PW-1:0]    sy;
      logic             sc;
      logic [SW:0]      slc;
`ifdef ADDSUB_SAT_EN
      logic             ss;
`endif

      if (k == 0) begin : g_head
         assign sx      = a;
         assign sy      = b ^ {WIDTH{sub}};
         assign sc      = sub;
         assign v_in[0] = in_valid;
`ifdef ADDSUB_SAT_EN
         assign ss      = sat;
`endif
      end else begin : g_tail
         assign sx      = g_stage[k-1].g_pipe.x_q;
         assign sy      = g_stage[k-1].g_pipe.y_q;
         assign sc      = g_stage[k-1].g_pipe.c_q;
         assign v_in[k] = v_q[k-1];
`ifdef ADDSUB_SAT_EN
         assign ss      = g_stage[k-1].g_pipe.s_q;
`endif
      end

      assign slc = {1'b0, sx[k*SW +: SW]} + {1'b0, sy[SW-1:0]} + {{SW{1'b0}}, sc};

      always_comb begin
         x_d              = sx;
         x_d[k*SW +: SW]  = slc[SW-1:0];
      end

      if (k < STAGES - 1) begin : g_pipe
         logic [WIDTH-1:0] x_q;
         logic [PW-SW-1:0] y_q;
         logic             c_q;
`ifdef ADDSUB_SAT_EN
         logic             s_q;
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               x_q <= '0;
               y_q <= '0;
               c_q <= 1'b0;
`ifdef ADDSUB_SAT_EN
               s_q <= 1'b0;
`endif
            end else if (ld[k] && v_in[k]) begin
               x_q <= x_d;
               y_q <= sy[PW-1:SW];
               c_q <= slc[SW];
`ifdef ADDSUB_SAT_EN
               s_q <= ss;
`endif
            end
         end
      end else begin : g_last
         logic [WIDTH-1:0] res_d, sum_q;
         logic             ov_d, carry_q, ov_q, zero_q, neg_q;

         // Carry into the MSB is recovered from the MSB operand and result bits.
         assign ov_d = (sx[WIDTH-1] ^ sy[PW-1] ^ x_d[WIDTH-1]) ^ slc[SW];

         always_comb begin
            res_d = x_d;
`ifdef ADDSUB_SAT_EN
            if (ss && ov_d) begin
               res_d = sx[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sum_q   <= '0;
               carry_q <= 1'b0;
               ov_q    <= 1'b0;
               zero_q  <= 1'b0;
               neg_q   <= 1'b0;
            end else if (ld[k] && v_in[k]) begin
               sum_q   <= res_d;
               carry_q <= slc[SW];
               ov_q    <= ov_d;
               zero_q  <= (res_d == '0);
               neg_q   <= res_d[WIDTH-1];
            end
         end

         assign sum      = sum_q;
         assign carry    = carry_q;
         assign overflow = ov_q;
         assign zero     = zero_q;
         assign negative = neg_q;
      end
   end

endmodule
